// File: rtl/mem_march_bist.sv
// rtl/mem_march_bist.sv - March-sequence BIST master for a valid/ready word memory
module mem_march_bist #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int TIMEOUT    = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      pattern,
    output logic                  valid,
    output logic                  wr_rd,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [WIDTH-1:0]      wdata,
    input  logic [WIDTH-1:0]      rdata,
    input  logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [15:0]           err_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [WIDTH-1:0]      fail_data,
    output logic [1:0]            fail_phase
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PH0_W = 3'd1,
        PH1_R = 3'd2,
        PH1_W = 3'd3,
        PH2_R = 3'd4,
        PH2_W = 3'd5,
        PH3_R = 3'd6,
        FIN   = 3'd7
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  pat;
    logic [TW-1:0]     stall_cnt;

    logic              handshake;
    logic              mismatch;
    logic              stall_expire;
    logic [WIDTH-1:0]  expected;
    logic [15:0]       err_next;
    logic [1:0]        phase_idx;

    always_comb begin
        handshake    = valid && ready;
        expected     = (state == PH2_R) ? ~pat : pat;
        mismatch     = handshake && !wr_rd && (rdata != expected);
        err_next     = (mismatch && (err_count != 16'hFFFF)) ? err_count + 16'd1 : err_count;
        stall_expire = valid && !ready && (stall_cnt == TW'(TIMEOUT - 1));
        case (state)
            PH1_R:   phase_idx = 2'd1;
            PH2_R:   phase_idx = 2'd2;
            PH3_R:   phase_idx = 2'd3;
            default: phase_idx = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            pat        <= '0;
            stall_cnt  <= '0;
            valid      <= 1'b0;
            wr_rd      <= 1'b0;
            addr       <= '0;
            wdata      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            timeout    <= 1'b0;
            err_count  <= '0;
            fail_addr  <= '0;
            fail_data  <= '0;
            fail_phase <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pat        <= pattern;
                        state      <= PH0_W;
                        addr       <= '0;
                        wr_rd      <= 1'b1;
                        wdata      <= pattern;
                        valid      <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        timeout    <= 1'b0;
                        err_count  <= '0;
                        fail_addr  <= '0;
                        fail_data  <= '0;
                        fail_phase <= '0;
                        stall_cnt  <= '0;
                    end
                end
                FIN: state <= IDLE;
                default: begin
                    if (stall_expire) begin
                        timeout <= 1'b1;
                        valid   <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= 1'b0;
                        state   <= FIN;
                    end else if (valid && !ready) begin
                        stall_cnt <= stall_cnt + TW'(1);
                    end else if (handshake) begin
                        stall_cnt <= '0;
                        err_count <= err_next;
                        // err_count still zero here means this is the first mismatch
                        if (mismatch && (err_count == 16'd0)) begin
                            fail_addr  <= addr;
                            fail_data  <= rdata;
                            fail_phase <= phase_idx;
                        end
                        case (state)
                            PH0_W: begin
                                if (addr == LAST) begin
                                    state <= PH1_R;
                                    addr  <= '0;
                                    wr_rd <= 1'b0;
                                end else begin
                                    addr  <= addr + ADDR_WIDTH'(1);
                                end
                            end
                            PH1_R: begin
                                state <= PH1_W;
                                wr_rd <= 1'b1;
                                wdata <= ~pat;
                            end
                            PH1_W: begin
                                wr_rd <= 1'b0;
                                if (addr == LAST) begin
                                    state <= PH2_R;
                                end else begin
                                    state <= PH1_R;
                                    addr  <= addr + ADDR_WIDTH'(1);
                                end
                            end
                            PH2_R: begin
                                state <= PH2_W;
                                wr_rd <= 1'b1;
                                wdata <= pat;
                            end
                            PH2_W: begin
                                wr_rd <= 1'b0;
                                if (addr == '0) begin
                                    state <= PH3_R;
                                    addr  <= LAST;
                                end else begin
                                    state <= PH2_R;
                                    addr  <= addr - ADDR_WIDTH'(1);
                                end
                            end
                            PH3_R: begin
                                if (addr == '0) begin
                                    state <= FIN;
                                    valid <= 1'b0;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                    pass  <= (err_next == 16'd0);
                                end else begin
                                    addr  <= addr - ADDR_WIDTH'(1);
                                end
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_march_bist.sv
// tb/tb_mem_march_bist.sv - directed bench for mem_march_bist with behavioural memory
module tb_mem_march_bist;

    localparam int WIDTH = 16;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [WIDTH-1:0]  pattern = '0;
    logic              valid, wr_rd, ready, busy, done, pass, timeout;
    logic [AW-1:0]     addr, fail_addr;
    logic [WIDTH-1:0]  wdata, rdata, fail_data;
    logic [15:0]       err_count;
    logic [1:0]        fail_phase;

    int n_cmp = 0;
    int n_err = 0;

    mem_march_bist #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern),
        .valid(valid), .wr_rd(wr_rd), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .busy(busy), .done(done), .pass(pass),
        .timeout(timeout), .err_count(err_count), .fail_addr(fail_addr),
        .fail_data(fail_data), .fail_phase(fail_phase)
    );

    always #5 clk = ~clk;

    // Memory model: ready policy selectable, optional stuck-at-1 on bit0 of word 5
    logic [WIDTH-1:0] mem [DEPTH];
    int  ready_mode = 0;
    bit  fault_en = 1'b0;
    int  cyc = 0;
    int  mhs = 0;
    int  mhs_base = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (valid && ready) begin
            mhs <= mhs + 1;
            if (wr_rd) mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr] | ((fault_en && addr == AW'(5)) ? 16'h0001 : 16'h0000);

    always_comb begin
        case (ready_mode)
            1:       ready = cyc[0];
            2:       ready = (mhs - mhs_base) < 10;
            default: ready = 1'b1;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Expected {wr_rd, addr, wdata} of the n-th handshake of a March run with pattern p
    function automatic logic [22:0] exp_req(input int n, input logic [15:0] p);
        int m;
        if (n < 64) return {1'b1, AW'(n), p};
        if (n < 192) begin
            m = n - 64;
            return {(m % 2) == 1, AW'(m / 2), ~p};
        end
        if (n < 320) begin
            m = n - 192;
            return {(m % 2) == 1, AW'(63 - m / 2), p};
        end
        return {1'b0, AW'(63 - (n - 320)), p};
    endfunction

    task automatic run(input logic [15:0] p, input int max_cyc, input int restart_at,
                       input int rst_at, output int hs, output int stalls, output int dcyc,
                       output int first_v, output int seq_err, output int stab_err);
        logic pv, pr, pw;
        logic [AW-1:0] pa;
        logic [15:0] pd;
        logic [22:0] e;
        hs = 0; stalls = 0; dcyc = -1; first_v = -1; seq_err = 0; stab_err = 0;
        pv = 1'b0; pr = 1'b1; pw = 1'b0; pa = '0; pd = '0;
        pattern = p;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 1; i <= max_cyc; i++) begin
            start = (i == restart_at);
            if (i == rst_at) begin
                #2 rst = 1'b0;
                #1;
                chk("arst_valid", 32'(valid), 32'd0);
                chk("arst_busy", 32'(busy), 32'd0);
                chk("arst_done", 32'(done), 32'd0);
                chk("arst_err", 32'(err_count), 32'd0);
                break;
            end
            if (done) begin
                dcyc = i;
                break;
            end
            if (pv && !pr && valid && ({pw, pa, pd} != {wr_rd, addr, wdata})) stab_err++;
            if (valid && first_v < 0) first_v = i;
            if (valid && !ready) stalls++;
            if (valid && ready) begin
                e = exp_req(hs, p);
                if (e[22]) begin
                    if (e != {wr_rd, addr, wdata}) seq_err++;
                end else if (e[22:16] != {wr_rd, addr}) seq_err++;
                hs++;
            end
            pv = valid; pr = ready; pw = wr_rd; pa = addr; pd = wdata;
            @(negedge clk);
        end
        start = 1'b0;
        if (dcyc < 0 && rst_at < 0) chk("run_bound", 32'(dcyc), 32'(max_cyc));
    endtask

    task automatic check_mem(input string tag, input logic [15:0] p);
        int bad = 0;
        for (int a = 0; a < DEPTH; a++) if (mem[a] !== p) bad++;
        chk(tag, 32'(bad), 32'd0);
    endtask

    int hs, stalls, dcyc, first_v, seq_err, stab_err;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Ideal memory
        run(16'hA5A5, 500, -1, -1, hs, stalls, dcyc, first_v, seq_err, stab_err);
        chk("t1_first_valid", 32'(first_v), 32'd1);
        chk("t1_hs", 32'(hs), 32'd384);
        chk("t1_done_cyc", 32'(dcyc), 32'd385);
        chk("t1_seq", 32'(seq_err), 32'd0);
        chk("t1_pass", 32'(pass), 32'd1);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_err", 32'(err_count), 32'd0);
        chk("t1_timeout", 32'(timeout), 32'd0);
        check_mem("t1_mem", 16'hA5A5);

        // Stuck-at-1 on bit0 of address 5
        fault_en = 1'b1;
        run(16'hA5A5, 500, -1, -1, hs, stalls, dcyc, first_v, seq_err, stab_err);
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_pass", 32'(pass), 32'd0);
        chk("t2_err", 32'(err_count), 32'd1);
        chk("t2_fail_addr", 32'(fail_addr), 32'd5);
        chk("t2_fail_data", 32'(fail_data), 32'h5A5B);
        chk("t2_fail_phase", 32'(fail_phase), 32'd2);
        fault_en = 1'b0;

        // ready toggling every cycle
        ready_mode = 1;
        run(16'h3C96, 900, -1, -1, hs, stalls, dcyc, first_v, seq_err, stab_err);
        chk("t3_stable", 32'(stab_err), 32'd0);
        chk("t3_hs", 32'(hs), 32'd384);
        chk("t3_seq", 32'(seq_err), 32'd0);
        chk("t3_pass", 32'(pass), 32'd1);
        chk("t3_within_770", 32'(dcyc > 0 && dcyc <= 770), 32'd1);
        check_mem("t3_mem", 16'h3C96);

        // ready stuck low after 10 handshakes
        ready_mode = 2;
        mhs_base = mhs;
        run(16'h1234, 100, -1, -1, hs, stalls, dcyc, first_v, seq_err, stab_err);
        chk("t4_hs", 32'(hs), 32'd10);
        chk("t4_stalls", 32'(stalls), 32'd16);
        chk("t4_done_cyc", 32'(dcyc), 32'd27);
        chk("t4_timeout", 32'(timeout), 32'd1);
        chk("t4_valid", 32'(valid), 32'd0);
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_pass", 32'(pass), 32'd0);
        ready_mode = 0;

        // start pulsed mid-run is ignored
        run(16'hA5A5, 500, 50, -1, hs, stalls, dcyc, first_v, seq_err, stab_err);
        chk("t5_hs", 32'(hs), 32'd384);
        chk("t5_done_cyc", 32'(dcyc), 32'd385);
        chk("t5_seq", 32'(seq_err), 32'd0);
        chk("t5_pass", 32'(pass), 32'd1);
        chk("t5_err", 32'(err_count), 32'd0);
        check_mem("t5_mem", 16'hA5A5);

        // Async reset mid-run, then a clean full test
        run(16'h0FF0, 500, -1, 100, hs, stalls, dcyc, first_v, seq_err, stab_err);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        run(16'h0FF0, 500, -1, -1, hs, stalls, dcyc, first_v, seq_err, stab_err);
        chk("t6_hs", 32'(hs), 32'd384);
        chk("t6_done_cyc", 32'(dcyc), 32'd385);
        chk("t6_seq", 32'(seq_err), 32'd0);
        chk("t6_pass", 32'(pass), 32'd1);
        check_mem("t6_mem", 16'h0FF0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
